// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl
//   x/y-steered sequence controller. Walks S7 -> {S10 -> S5 -> {S6 -> S1 | S1 | S9} | S9},
//   dwells HOLD enabled cycles in the terminal states S1/S9, then returns to S7 with a
//   one-cycle done pulse. Code 6 is illegal and leads to a sticky ERR state that only
//   clr or reset can leave.
//
//   state | meaning
//   ------+---------------------------------------------
//   S7    | idle, waits for y=1 (code 0)
//   S10   | first step of the x=0 branch (code 5)
//   S5    | branch point steered by x/y (code 2)
//   S6    | pass-through into S1 (code 3)
//   S1    | terminal, dwell HOLD cycles (code 1)
//   S9    | terminal, dwell HOLD cycles (code 4)
//   ERR   | sticky error after an illegal code (code 7)
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   en    in   advance enable; 0 holds state, counter and z
//   clr   in   synchronous return to S7, wins over en
//   x, y  in   steering inputs
//   z     out  registered per-state output code (ZW bits)
//   state out  current state encoding
//   err   out  high while in ERR
//   done  out  one-cycle pulse after a dwell-expiry exit
module fsm_seq_ctrl #(
   parameter int ZW    = 3,
   parameter int Z_S7  = 0,
   parameter int Z_S1  = 5,
   parameter int Z_S5  = 1,
   parameter int Z_S6  = 2,
   parameter int Z_S9  = 1,
   parameter int Z_S10 = 0,
   parameter int Z_ERR = 7,
   parameter int HOLD  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic          x,
   input  logic          y,
   output logic [ZW-1:0] z,
   output logic [2:0]    state,
   output logic          err,
   output logic          done
);

   localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (HOLD > 0) ? CW'(HOLD - 1) : '0;

   typedef enum logic [2:0] {
      S7    = 3'd0,
      S1    = 3'd1,
      S5    = 3'd2,
      S6    = 3'd3,
      S9    = 3'd4,
      S10   = 3'd5,
      S_ILL = 3'd6,
      ERR   = 3'd7
   } state_e;

   // Plain vector register so an illegal code can physically exist and be decoded.
   logic [2:0]    state_q;
   state_e        state_d;
   state_e        cur;
   state_e        nxt;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [ZW-1:0] z_q, z_d;
   logic          done_q, done_d;
   logic          expire;
   logic          in_term;

   function automatic logic [ZW-1:0] z_code(input state_e s);
      case (s)
         S7:      z_code = ZW'(Z_S7);
         S1:      z_code = ZW'(Z_S1);
         S5:      z_code = ZW'(Z_S5);
         S6:      z_code = ZW'(Z_S6);
         S9:      z_code = ZW'(Z_S9);
         S10:     z_code = ZW'(Z_S10);
         default: z_code = ZW'(Z_ERR);
      endcase
   endfunction

   always_comb begin
      cur    = state_e'(state_q);
      nxt    = cur;
      expire = 1'b0;
      case (cur)
         S7:  if (y) nxt = x ? S9 : S10;
         S10: nxt = S5;
         S5: begin
            if (y)      nxt = S1;
            else if (x) nxt = S9;
            else        nxt = S6;
         end
         S6:  nxt = S1;
         S1, S9: begin
            if (HOLD != 0 && cnt_q == CNT_LAST) begin
               nxt    = S7;
               expire = 1'b1;
            end
         end
         ERR:     nxt = ERR;
         default: nxt = ERR;
      endcase

      in_term = (cur == S1) || (cur == S9);

      state_d = cur;
      cnt_d   = cnt_q;
      z_d     = z_q;
      done_d  = 1'b0;
      if (clr) begin
         state_d = S7;
         cnt_d   = '0;
         z_d     = z_code(S7);
      end else if (en) begin
         state_d = nxt;
         // z follows the next state so it lines up with the state register.
         z_d     = z_code(nxt);
         done_d  = expire;
         // Count only while remaining in a terminal state; any entry starts from zero.
         if (in_term && nxt == cur && HOLD != 0) cnt_d = cnt_q + 1'b1;
         else                                    cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S7;
         cnt_q   <= '0;
         z_q     <= ZW'(Z_S7);
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         done_q  <= done_d;
      end
   end

   assign z     = z_q;
   assign state = state_q;
   assign err   = (state_q == ERR);
   assign done  = done_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb_fsm_seq_ctrl
//   Drives two controllers in parallel (HOLD=4 and HOLD=0) from the same inputs.
//   A behavioural model tracks each one by state number and elapsed dwell cycles;
//   every cycle the outputs of both are compared with it, and directed literal
//   checks pin the model at the interesting points of each scenario.
module tb_fsm_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;
   logic clr = 1'b0;
   logic x   = 1'b0;
   logic y   = 1'b0;

   logic [2:0] z_a, z_b, st_a, st_b;
   logic       err_a, err_b, done_a, done_b;

   int n_vec  = 0;
   int n_err  = 0;
   bit chk_en = 1'b0;

   int hold_of[2] = '{4, 0};
   int m_st[2]    = '{0, 0};
   int m_dw[2]    = '{0, 0};
   bit m_done[2]  = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   fsm_seq_ctrl #(.ZW(3), .Z_S7(0), .Z_S1(5), .Z_S5(1), .Z_S6(2), .Z_S9(1),
                  .Z_S10(0), .Z_ERR(7), .HOLD(4)) dut_a (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y),
      .z(z_a), .state(st_a), .err(err_a), .done(done_a));

   fsm_seq_ctrl #(.ZW(3), .Z_S7(0), .Z_S1(5), .Z_S5(1), .Z_S6(2), .Z_S9(1),
                  .Z_S10(0), .Z_ERR(7), .HOLD(0)) dut_b (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y),
      .z(z_b), .state(st_b), .err(err_b), .done(done_b));

   // State numbers: 0=S7 1=S1 2=S5 3=S6 4=S9 5=S10 7=ERR
   function automatic int succ(input int s, input bit xi, input bit yi);
      case (s)
         0:       return yi ? (xi ? 4 : 5) : 0;
         5:       return 2;
         2:       return yi ? 1 : (xi ? 4 : 3);
         3:       return 1;
         default: return 7;
      endcase
   endfunction

   function automatic int zcode(input int s);
      case (s)
         0: return 0;
         1: return 5;
         2: return 1;
         3: return 2;
         4: return 1;
         5: return 0;
         default: return 7;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            m_st[k] = 0; m_dw[k] = 0; m_done[k] = 1'b0;
         end else if (clr) begin
            m_st[k] = 0; m_dw[k] = 0; m_done[k] = 1'b0;
         end else if (!en) begin
            m_done[k] = 1'b0;
         end else begin
            m_done[k] = 1'b0;
            if (m_st[k] == 1 || m_st[k] == 4) begin
               m_dw[k]++;
               if (hold_of[k] != 0 && m_dw[k] == hold_of[k]) begin
                  m_st[k] = 0; m_dw[k] = 0; m_done[k] = 1'b1;
               end
            end else begin
               m_st[k] = succ(m_st[k], x, y);
               m_dw[k] = 0;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always begin
      @(negedge clk);
      #1;
      if (chk_en) begin
         check("a.state", int'(st_a),  m_st[0]);
         check("a.z",     int'(z_a),   zcode(m_st[0]));
         check("a.err",   int'(err_a), (m_st[0] == 7) ? 1 : 0);
         check("a.done",  int'(done_a), int'(m_done[0]));
         check("b.state", int'(st_b),  m_st[1]);
         check("b.z",     int'(z_b),   zcode(m_st[1]));
         check("b.err",   int'(err_b), (m_st[1] == 7) ? 1 : 0);
         check("b.done",  int'(done_b), int'(m_done[1]));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // 1: reset and idle
      rst = 1'b0; en = 1'b1; clr = 1'b0; x = 1'b0; y = 1'b0;
      cyc(2);
      check("rst.state", int'(st_a), 0);
      check("rst.z",     int'(z_a), 0);
      check("rst.err",   int'(err_a), 0);
      check("rst.done",  int'(done_a), 0);
      chk_en = 1'b1;
      rst = 1'b1;
      cyc(5);
      check("idle.state", int'(st_a), 0);

      // 2: S10 -> S5 -> S6 -> S1, dwell 4, done pulse
      y = 1'b1; x = 1'b0; cyc(1);
      check("s10.state", int'(st_a), 5); check("s10.z", int'(z_a), 0);
      y = 1'b0; cyc(1);
      check("s5.state", int'(st_a), 2);  check("s5.z", int'(z_a), 1);
      cyc(1);
      check("s6.state", int'(st_a), 3);  check("s6.z", int'(z_a), 2);
      cyc(1);
      check("s1.state", int'(st_a), 1);  check("s1.z", int'(z_a), 5);
      cyc(3);
      check("s1.dwell", int'(st_a), 1);  check("s1.nodone", int'(done_a), 0);
      cyc(1);
      check("s1.exit", int'(st_a), 0);   check("s1.done", int'(done_a), 1);
      cyc(1);
      check("s1.donefall", int'(done_a), 0);

      // 3: S9 dwell with en=0 gap
      y = 1'b1; x = 1'b1; cyc(1);
      check("s9.state", int'(st_a), 4);  check("s9.z", int'(z_a), 1);
      y = 1'b0; x = 1'b0; cyc(2);
      en = 1'b0; x = 1'b1; y = 1'b1; cyc(3);
      check("hold.state", int'(st_a), 4); check("hold.done", int'(done_a), 0);
      en = 1'b1; x = 1'b0; y = 1'b0; cyc(1);
      check("s9.dwell3", int'(st_a), 4);
      cyc(1);
      check("s9.exit", int'(st_a), 0);   check("s9.done", int'(done_a), 1);

      // 4: illegal code -> sticky ERR, clr recovers even with en=0
      chk_en = 1'b0;
      force dut_a.state_q = 3'd6;
      m_st[0] = 6;
      #1 release dut_a.state_q;
      @(posedge clk);
      #1 chk_en = 1'b1;
      cyc(1);
      check("err.state", int'(st_a), 7); check("err.z", int'(z_a), 7);
      check("err.err", int'(err_a), 1);
      for (int i = 0; i < 4; i++) begin
         x = i[0]; y = i[1]; cyc(1);
      end
      check("err.sticky", int'(st_a), 7);
      en = 1'b0; clr = 1'b1; x = 1'b1; y = 1'b1; cyc(1);
      check("clr.state", int'(st_a), 0); check("clr.err", int'(err_a), 0);
      check("clr.z", int'(z_a), 0);
      clr = 1'b0; en = 1'b1; x = 1'b0; y = 1'b0;

      // 5: HOLD=0 instance absorbs in S1
      y = 1'b1; cyc(3);
      check("h0.enter", int'(st_b), 1);
      y = 1'b0; cyc(20);
      check("h0.stay", int'(st_b), 1);  check("h0.nodone", int'(done_b), 0);
      clr = 1'b1; cyc(1); clr = 1'b0;

      // 6: async reset in S5, then full dwell; and reset mid-dwell
      y = 1'b1; x = 1'b0; cyc(1);
      y = 1'b0; cyc(1);
      check("r.s5", int'(st_a), 2);
      #2 rst = 1'b0;
      #1;
      check("r.async.state", int'(st_a), 0); check("r.async.z", int'(z_a), 0);
      cyc(1); rst = 1'b1;
      y = 1'b1; x = 1'b1; cyc(1);
      check("r.s9", int'(st_a), 4);
      y = 1'b0; x = 1'b0; cyc(3);
      check("r.s9.dwell", int'(st_a), 4);
      cyc(1);
      check("r.s9.exit", int'(st_a), 0); check("r.s9.done", int'(done_a), 1);
      y = 1'b1; x = 1'b1; cyc(1);
      y = 1'b0; x = 1'b0; cyc(2);
      #2 rst = 1'b0;
      cyc(1); rst = 1'b1;
      y = 1'b1; x = 1'b1; cyc(1);
      y = 1'b0; x = 1'b0; cyc(3);
      check("rd.dwell", int'(st_a), 4);
      cyc(1);
      check("rd.exit", int'(st_a), 0);   check("rd.done", int'(done_a), 1);
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
